// File: rtl/gpu_data_memory.sv
// gpu_data_memory: multi-channel, fixed-latency valid/ready memory responder with a backdoor load port.
// Define GPU_MEM_COLLISION_FLAG_EN to add the sticky mem_collision output.
module gpu_data_memory #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  input  logic                    load_enable,
  input  logic [ADDR_BITS-1:0]    load_address,
  input  logic [DATA_BITS-1:0]    load_data
`ifdef GPU_MEM_COLLISION_FLAG_EN
  ,
  output logic                    mem_collision
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ_BUSY,
    WRITE_BUSY,
    RESPOND,
    RELEASE
  } state_t;

  state_t                  state_q   [NUM_CHANNELS];
  state_t                  state_d   [NUM_CHANNELS];
  logic [3:0]              count_q   [NUM_CHANNELS];
  logic [3:0]              count_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    addr_q    [NUM_CHANNELS];
  logic [ADDR_BITS-1:0]    addr_d    [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wdata_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    wdata_d   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rdata_q   [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    rdata_d   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] op_write_q, op_write_d;
  logic [NUM_CHANNELS-1:0] rready_q, rready_d;
  logic [NUM_CHANNELS-1:0] wready_q, wready_d;
  logic [NUM_CHANNELS-1:0] rd_fire, wr_fire;

  logic [DATA_BITS-1:0]    mem_array [DEPTH];

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c]    = state_q[c];
      count_d[c]    = count_q[c];
      addr_d[c]     = addr_q[c];
      wdata_d[c]    = wdata_q[c];
      rdata_d[c]    = rdata_q[c];
      op_write_d[c] = op_write_q[c];
      rready_d[c]   = 1'b0;
      wready_d[c]   = 1'b0;
      rd_fire[c]    = 1'b0;
      wr_fire[c]    = 1'b0;
      case (state_q[c])
        IDLE: begin
          if (mem_read_valid[c]) begin
            addr_d[c]     = mem_read_address[c];
            count_d[c]    = COUNT_INIT;
            op_write_d[c] = 1'b0;
            state_d[c]    = READ_BUSY;
          end else if (mem_write_valid[c]) begin
            addr_d[c]     = mem_write_address[c];
            wdata_d[c]    = mem_write_data[c];
            count_d[c]    = COUNT_INIT;
            op_write_d[c] = 1'b1;
            state_d[c]    = WRITE_BUSY;
          end
        end
        READ_BUSY: begin
          if (count_q[c] == 4'd0) begin
            rd_fire[c]  = 1'b1;
            rdata_d[c]  = mem_array[addr_q[c]];
            rready_d[c] = 1'b1;
            state_d[c]  = RESPOND;
          end else begin
            count_d[c] = count_q[c] - 4'd1;
          end
        end
        WRITE_BUSY: begin
          if (count_q[c] == 4'd0) begin
            wr_fire[c]  = 1'b1;
            wready_d[c] = 1'b1;
            state_d[c]  = RESPOND;
          end else begin
            count_d[c] = count_q[c] - 4'd1;
          end
        end
        RESPOND: state_d[c] = RELEASE;
        // Hold here until the requester lets go, so a lingering valid is not serviced twice.
        RELEASE: begin
          if (!(op_write_q[c] ? mem_write_valid[c] : mem_read_valid[c])) begin
            state_d[c] = IDLE;
          end
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        count_q[c] <= 4'd0;
        addr_q[c]  <= '0;
        wdata_q[c] <= '0;
        rdata_q[c] <= '0;
      end
      op_write_q <= '0;
      rready_q   <= '0;
      wready_q   <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        count_q[c] <= count_d[c];
        addr_q[c]  <= addr_d[c];
        wdata_q[c] <= wdata_d[c];
        rdata_q[c] <= rdata_d[c];
      end
      op_write_q <= op_write_d;
      rready_q   <= rready_d;
      wready_q   <= wready_d;
    end
  end

  // Later assignments win: channel writes override the load port, higher channels override lower.
  always_ff @(posedge clk) begin
    if (load_enable) begin
      mem_array[load_address] <= load_data;
    end
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (wr_fire[c]) begin
        mem_array[addr_q[c]] <= wdata_q[c];
      end
    end
  end

  assign mem_read_ready  = rready_q;
  assign mem_write_ready = wready_q;
  assign mem_read_data   = rdata_q;

`ifdef GPU_MEM_COLLISION_FLAG_EN
  logic collision_q, collision_d;
  logic collision_hit;

  always_comb begin
    collision_hit = 1'b0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      for (int j = 0; j < NUM_CHANNELS; j++) begin
        if (wr_fire[i] && (addr_q[i] == addr_q[j])) begin
          if ((j > i) && wr_fire[j]) collision_hit = 1'b1;
          if ((j != i) && rd_fire[j]) collision_hit = 1'b1;
        end
      end
    end
    collision_d = collision_q | collision_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      collision_q <= 1'b0;
    end else begin
      collision_q <= collision_d;
    end
  end

  assign mem_collision = collision_q;
`endif

endmodule

// File: tb/tb_gpu_data_memory.sv
// tb_gpu_data_memory: randomized self-checking bench for gpu_data_memory against a word-array reference model.
// Checks mem_collision too when GPU_MEM_COLLISION_FLAG_EN is defined.
module tb_gpu_data_memory;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;
  localparam int WIN = 2 * LAT + 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NC-1:0] rv = '0;
  logic [AB-1:0] ra [NC];
  logic [NC-1:0] rr;
  logic [DB-1:0] rd [NC];
  logic [NC-1:0] wv = '0;
  logic [AB-1:0] wa [NC];
  logic [DB-1:0] wd [NC];
  logic [NC-1:0] wr;
  logic          load_enable = 1'b0;
  logic [AB-1:0] load_address = '0;
  logic [DB-1:0] load_data = '0;
`ifdef GPU_MEM_COLLISION_FLAG_EN
  logic          mem_collision;
`endif

  int checks = 0;
  int errors = 0;

  logic [DB-1:0] model_mem [1 << AB];
  logic          model_coll = 1'b0;

  int            rd_k [NC];
  int            wr_k [NC];
  int            rd_n [NC];
  int            wr_n [NC];
  logic [DB-1:0] rd_v [NC];

  gpu_data_memory #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_read_valid(rv),
    .mem_read_address(ra),
    .mem_read_ready(rr),
    .mem_read_data(rd),
    .mem_write_valid(wv),
    .mem_write_address(wa),
    .mem_write_data(wd),
    .mem_write_ready(wr),
    .load_enable(load_enable),
    .load_address(load_address),
    .load_data(load_data)
`ifdef GPU_MEM_COLLISION_FLAG_EN
    ,
    .mem_collision(mem_collision)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [AB-1:0] a, input logic [DB-1:0] d);
    load_enable  = 1'b1;
    load_address = a;
    load_data    = d;
    tick();
    load_enable  = 1'b0;
    model_mem[a] = d;
  endtask

  // Raise the requested valids, then record when and how often each ready pulses over a fixed window.
  task automatic do_requests(input logic [NC-1:0] rmask, input logic [NC-1:0] wmask,
                             input int extra_hold, input bit scramble);
    int rdrop [NC];
    int wdrop [NC];
    for (int c = 0; c < NC; c++) begin
      rd_k[c] = -1; wr_k[c] = -1; rd_n[c] = 0; wr_n[c] = 0; rd_v[c] = '0;
      rdrop[c] = -1; wdrop[c] = -1;
    end
    rv = rmask;
    wv = wmask;
    for (int k = 1; k <= WIN; k++) begin
      tick();
      if (scramble && k == 1) begin
        for (int c = 0; c < NC; c++) begin
          ra[c] = AB'($urandom);
          wa[c] = AB'($urandom);
          wd[c] = DB'($urandom);
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (rr[c]) begin
          rd_n[c]++;
          if (rd_k[c] < 0) begin
            rd_k[c]  = k;
            rd_v[c]  = rd[c];
            rdrop[c] = k + extra_hold;
          end
        end
        if (wr[c]) begin
          wr_n[c]++;
          if (wr_k[c] < 0) begin
            wr_k[c]  = k;
            wdrop[c] = k + extra_hold;
          end
        end
        if (rdrop[c] >= 0 && k >= rdrop[c]) rv[c] = 1'b0;
        if (wdrop[c] >= 0 && k >= wdrop[c]) wv[c] = 1'b0;
      end
    end
    rv = '0;
    wv = '0;
  endtask

  task automatic test_reset();
    for (int a = 0; a < (1 << AB); a++) begin
      load_word(AB'(a), DB'($urandom));
    end
    checks++;
    if (rr !== '0 || wr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ready: read_ready=%b write_ready=%b, required 0", rr, wr);
    end
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (rd[c] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_data ch%0d: got %h, required 00", c, rd[c]);
      end
    end
`ifdef GPU_MEM_COLLISION_FLAG_EN
    checks++;
    if (mem_collision !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_collision: got %b, required 0", mem_collision);
    end
`endif
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    load_word(8'h10, 8'hA5);
    ra[0] = 8'h10;
    do_requests(4'b0001, 4'b0000, 3, 1'b0);
    checks++;
    if (rd_k[0] !== LAT + 1) begin
      errors++;
      $display("[TB] FAIL single_read_latency: ready at cycle %0d, required %0d", rd_k[0], LAT + 1);
    end
    checks++;
    if (rd_n[0] !== 1) begin
      errors++;
      $display("[TB] FAIL single_read_pulses: %0d pulses, required 1", rd_n[0]);
    end
    checks++;
    if (rd_v[0] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_read_data: got %h, required a5", rd_v[0]);
    end
    checks++;
    if (rd[0] !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL single_read_hold: got %h, required a5", rd[0]);
    end
  endtask

  task automatic test_write_then_read();
    wa[1] = 8'h20;
    wd[1] = 8'h3C;
    do_requests(4'b0000, 4'b0010, 0, 1'b0);
    model_mem[8'h20] = 8'h3C;
    checks++;
    if (wr_n[1] !== 1 || wr_k[1] !== LAT + 1) begin
      errors++;
      $display("[TB] FAIL write_ready: %0d pulses at cycle %0d, required 1 at %0d", wr_n[1], wr_k[1], LAT + 1);
    end
    ra[2] = 8'h20;
    do_requests(4'b0100, 4'b0000, 0, 1'b0);
    checks++;
    if (rd_v[2] !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL write_then_read_data: got %h, required 3c", rd_v[2]);
    end
  endtask

  task automatic test_parallel_reads();
    for (int c = 0; c < NC; c++) load_word(AB'(c), DB'(c + 1));
    for (int c = 0; c < NC; c++) ra[c] = AB'(c);
    do_requests(4'b1111, 4'b0000, 0, 1'b0);
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (rd_k[c] !== LAT + 1 || rd_v[c] !== DB'(c + 1)) begin
        errors++;
        $display("[TB] FAIL parallel_read ch%0d: cycle %0d data %h, required cycle %0d data %h",
                 c, rd_k[c], rd_v[c], LAT + 1, DB'(c + 1));
      end
    end
  endtask

  task automatic test_write_collision();
    wa[0] = 8'h40; wd[0] = 8'h11;
    wa[3] = 8'h40; wd[3] = 8'h33;
    do_requests(4'b0000, 4'b1001, 0, 1'b0);
    model_mem[8'h40] = 8'h33;
    model_coll = 1'b1;
    checks++;
    if (wr_k[0] !== LAT + 1 || wr_k[3] !== LAT + 1) begin
      errors++;
      $display("[TB] FAIL collision_ready: ch0 cycle %0d ch3 cycle %0d, required %0d", wr_k[0], wr_k[3], LAT + 1);
    end
    ra[1] = 8'h40;
    do_requests(4'b0010, 4'b0000, 0, 1'b0);
    checks++;
    if (rd_v[1] !== 8'h33) begin
      errors++;
      $display("[TB] FAIL collision_winner: got %h, required 33", rd_v[1]);
    end
`ifdef GPU_MEM_COLLISION_FLAG_EN
    checks++;
    if (mem_collision !== model_coll) begin
      errors++;
      $display("[TB] FAIL collision_flag: got %b, required %b", mem_collision, model_coll);
    end
`endif
  endtask

  task automatic test_read_write_same_channel();
    load_word(8'h05, 8'h07);
    ra[0] = 8'h05;
    wa[0] = 8'h05;
    wd[0] = 8'h09;
    do_requests(4'b0001, 4'b0001, 0, 1'b0);
    model_mem[8'h05] = 8'h09;
    checks++;
    if (rd_k[0] !== LAT + 1 || rd_v[0] !== 8'h07) begin
      errors++;
      $display("[TB] FAIL rw_read_first: cycle %0d data %h, required cycle %0d data 07", rd_k[0], rd_v[0], LAT + 1);
    end
    checks++;
    if (wr_k[0] !== 2 * LAT + 4 || wr_n[0] !== 1) begin
      errors++;
      $display("[TB] FAIL rw_write_after: cycle %0d pulses %0d, required cycle %0d pulses 1", wr_k[0], wr_n[0], 2 * LAT + 4);
    end
    do_requests(4'b0001, 4'b0000, 0, 1'b0);
    checks++;
    if (rd_v[0] !== 8'h09) begin
      errors++;
      $display("[TB] FAIL rw_readback: got %h, required 09", rd_v[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    load_word(8'h60, 8'h5A);
    ra[2] = 8'h60;
    wa[1] = 8'h60;
    wd[1] = 8'hEE;
    rv = 4'b0100;
    wv = 4'b0010;
    tick();
    tick();
    reset = 1'b0;
    #1;
    rv = '0;
    wv = '0;
    model_coll = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rr !== '0 || wr !== '0 || rd[2] !== '0) begin
        errors++;
        $display("[TB] FAIL reset_mid_read %0d: rready=%b wready=%b data=%h, required 0/0/00", k, rr, wr, rd[2]);
      end
      tick();
    end
`ifdef GPU_MEM_COLLISION_FLAG_EN
    checks++;
    if (mem_collision !== model_coll) begin
      errors++;
      $display("[TB] FAIL reset_collision_clear: got %b, required %b", mem_collision, model_coll);
    end
`endif
    reset = 1'b1;
    tick();
    do_requests(4'b0100, 4'b0000, 0, 1'b0);
    checks++;
    if (rd_k[2] !== LAT + 1 || rd_v[2] !== model_mem[8'h60]) begin
      errors++;
      $display("[TB] FAIL after_reset_read: cycle %0d data %h, required cycle %0d data %h",
               rd_k[2], rd_v[2], LAT + 1, model_mem[8'h60]);
    end
  endtask

  // Every channel launches in the same cycle: reads see the pre-round array, writes land highest-channel-last.
  task automatic test_random();
    logic [NC-1:0] rmask, wmask;
    logic [AB-1:0] op_addr [NC];
    logic [DB-1:0] exp_rd [NC];
    for (int round = 0; round < 40; round++) begin
      rmask = '0;
      wmask = '0;
      for (int c = 0; c < NC; c++) begin
        int op;
        op         = int'($urandom_range(0, 2));
        op_addr[c] = AB'($urandom_range(0, 7));
        ra[c]      = op_addr[c];
        wa[c]      = op_addr[c];
        wd[c]      = DB'($urandom);
        if (op == 1) rmask[c] = 1'b1;
        if (op == 2) wmask[c] = 1'b1;
        exp_rd[c]  = model_mem[op_addr[c]];
      end
      for (int i = 0; i < NC; i++) begin
        for (int j = 0; j < NC; j++) begin
          if (i != j && wmask[i] && (wmask[j] || rmask[j]) && op_addr[i] == op_addr[j]) model_coll = 1'b1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (wmask[c]) model_mem[op_addr[c]] = wd[c];
      end
      do_requests(rmask, wmask, 0, 1'b1);
      for (int c = 0; c < NC; c++) begin
        checks++;
        if (rmask[c]) begin
          if (rd_k[c] !== LAT + 1 || rd_n[c] !== 1 || wr_n[c] !== 0 || rd_v[c] !== exp_rd[c]) begin
            errors++;
            $display("[TB] FAIL random_read r%0d ch%0d: cycle %0d pulses %0d data %h, required cycle %0d pulses 1 data %h",
                     round, c, rd_k[c], rd_n[c], rd_v[c], LAT + 1, exp_rd[c]);
          end
        end else if (wmask[c]) begin
          if (wr_k[c] !== LAT + 1 || wr_n[c] !== 1 || rd_n[c] !== 0) begin
            errors++;
            $display("[TB] FAIL random_write r%0d ch%0d: cycle %0d pulses %0d, required cycle %0d pulses 1",
                     round, c, wr_k[c], wr_n[c], LAT + 1);
          end
        end else begin
          if (rd_n[c] !== 0 || wr_n[c] !== 0) begin
            errors++;
            $display("[TB] FAIL random_idle r%0d ch%0d: read pulses %0d write pulses %0d, required 0",
                     round, c, rd_n[c], wr_n[c]);
          end
        end
      end
`ifdef GPU_MEM_COLLISION_FLAG_EN
      checks++;
      if (mem_collision !== model_coll) begin
        errors++;
        $display("[TB] FAIL random_collision r%0d: got %b, required %b", round, mem_collision, model_coll);
      end
`endif
    end
  endtask

  initial begin
    for (int c = 0; c < NC; c++) begin
      ra[c] = '0;
      wa[c] = '0;
      wd[c] = '0;
    end
    test_reset();
    test_single_read();
    test_write_then_read();
    test_parallel_reads();
    test_write_collision();
    test_read_write_same_channel();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
